// File: rtl/spi_frame_controller.sv
// SPI mode-0 slave that turns 16-bit command/data frames into single-cycle
// register accesses. All SPI pins are resynchronised into the clk domain.
module spi_frame_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] addr_bus,
  output logic       addr_sel,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_ACCESS, RD_CAPTURE, DATA, WR_COMMIT, WAIT_CS
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, valid_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, rx_shift;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  addr_q, addr_d, addr_hold_q, addr_hold_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rw_q, rw_d;
  logic        frame_err_q, frame_err_d;
  logic        armed_q, armed_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      valid_q     <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      valid_q     <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      addr_hold_q <= '0;
      wr_data_q   <= '0;
      rw_q        <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      addr_hold_q <= addr_hold_d;
      wr_data_q   <= wr_data_d;
      rw_q        <= rw_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    addr_hold_d = addr_hold_q;
    wr_data_d   = wr_data_q;
    rw_d        = rw_q;
    frame_err_d = 1'b0;
    // A CS low level still present when reset releases must not open a frame:
    // only a fall after a genuinely sampled high counts.
    armed_d     = armed_q | (valid_q[SYNC_STAGES-1] & cs_s);
    rx_shift    = {rx_q[6:0], mosi_s};

    if (cs_s)
      bit_cnt_d = '0;
    else if (sck_rise && bit_cnt_q != 5'd31)
      bit_cnt_d = bit_cnt_q + 5'd1;
    if (sck_rise)
      rx_d = rx_shift;

    case (state_q)
      IDLE: begin
        tx_d = '0;
        if (armed_q && cs_fall) state_d = CMD;
      end
      CMD: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sck_rise && bit_cnt_q == 5'd7) begin
          rw_d        = rx_shift[7];
          addr_hold_d = rx_shift[6:3];
          if (rx_shift[7]) begin
            state_d = DATA;
          end else begin
            addr_d  = rx_shift[6:3];
            state_d = RD_ACCESS;
          end
        end
      end
      RD_ACCESS: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          state_d = RD_CAPTURE;
        end
      end
      RD_CAPTURE: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          tx_d    = rd_data;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          // Falls after rises 9..15 advance the read byte; bit 7 is already out.
          if (!rw_q && sck_fall && bit_cnt_q >= 5'd9 && bit_cnt_q <= 5'd15)
            tx_d = {tx_q[6:0], 1'b0};
          if (sck_rise && bit_cnt_q == 5'd15) begin
            if (rw_q) begin
              addr_d    = addr_hold_q;
              wr_data_d = rx_shift;
              state_d   = WR_COMMIT;
            end else begin
              state_d = WAIT_CS;
            end
          end
        end
      end
      WR_COMMIT: state_d = WAIT_CS;
      WAIT_CS:   if (cs_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign spi_miso  = tx_q[7];
  assign addr_bus  = addr_q;
  assign wr_data   = wr_data_q;
  assign rd_en     = (state_q == RD_ACCESS);
  assign wr_en     = (state_q == WR_COMMIT);
  assign addr_sel  = rd_en | wr_en;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Directed bench for spi_frame_controller: host-side SPI driver, a strobe
// monitor with a small read-data responder, and one task per scenario.
`timescale 1ns/1ps
module tb_spi_frame_controller;

  localparam int HALF = 10;  // SCK half period in clk cycles (5 MHz at 100 MHz)

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [3:0] addr_bus;
  logic       addr_sel;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  int sel_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, bad_strobe = 0;
  int host_rises = 0;
  int wr_rise_at = 0;
  logic [3:0] last_wr_addr = 4'h0;
  logic [7:0] last_wr_data = 8'h00;
  logic [3:0] rd_log [0:7];
  logic [7:0] rd_mem [0:15];

  spi_frame_controller #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .addr_bus  (addr_bus),
    .addr_sel  (addr_sel),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor and read responder (rd_data valid the cycle after rd_en)
  always @(negedge clk) begin
    if (addr_sel) sel_cnt++;
    if (wr_en) begin
      wr_cnt++;
      last_wr_addr = addr_bus;
      last_wr_data = wr_data;
      wr_rise_at   = host_rises;
    end
    if (rd_en) begin
      rd_log[rd_cnt % 8] = addr_bus;
      rd_cnt++;
      rd_data = rd_mem[addr_bus];
    end
    if (frame_err) err_cnt++;
    if ((rd_en && wr_en) || ((rd_en || wr_en) != addr_sel)) bad_strobe++;
  end

  task automatic spi_frame(input logic [23:0] bits, input int nbits, input int cs_high,
                           input bit keep_cs, output logic [7:0] miso_b);
    miso_b     = 8'h00;
    host_rises = 0;
    spi_cs_n   = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[23-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) miso_b = {miso_b[6:0], spi_miso};
      spi_sck = 1'b1;
      host_rises++;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
    if (!keep_cs) begin
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (cs_high) @(negedge clk);
    end
    $display("frame bits=%h n=%0d miso=%h sel=%0d wr=%0d rd=%0d err=%0d",
             bits, nbits, miso_b, sel_cnt, wr_cnt, rd_cnt, err_cnt);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({spi_miso, addr_bus, addr_sel, wr_en, wr_data, rd_en, frame_err} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {spi_miso, addr_bus, addr_sel, wr_en, wr_data, rd_en, frame_err});
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    int s_sel = sel_cnt, s_wr = wr_cnt, s_rd = rd_cnt, s_err = err_cnt;
    logic [7:0] m;
    spi_frame(24'hA89A00, 16, 20, 1'b0, m);
    n_cmp++;
    if (wr_cnt - s_wr !== 1) begin n_bad++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - s_wr); end
    n_cmp++;
    if (sel_cnt - s_sel !== 1) begin n_bad++; $display("FAIL wr_sel: got %0d want 1", sel_cnt - s_sel); end
    n_cmp++;
    if (rd_cnt - s_rd !== 0) begin n_bad++; $display("FAIL wr_no_rd: got %0d want 0", rd_cnt - s_rd); end
    n_cmp++;
    if (last_wr_addr !== 4'h5) begin n_bad++; $display("FAIL wr_addr: got %h want 5", last_wr_addr); end
    n_cmp++;
    if (last_wr_data !== 8'h9A) begin n_bad++; $display("FAIL wr_data: got %h want 9a", last_wr_data); end
    n_cmp++;
    if (wr_rise_at !== 16) begin n_bad++; $display("FAIL wr_timing: after rise %0d want 16", wr_rise_at); end
    n_cmp++;
    if (err_cnt - s_err !== 0) begin n_bad++; $display("FAIL wr_err: got %0d want 0", err_cnt - s_err); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read();
    int s_sel = sel_cnt, s_wr = wr_cnt, s_rd = rd_cnt;
    logic [7:0] m;
    spi_frame(24'h600000, 16, 20, 1'b0, m);
    n_cmp++;
    if (rd_cnt - s_rd !== 1) begin n_bad++; $display("FAIL rd_pulses: got %0d want 1", rd_cnt - s_rd); end
    n_cmp++;
    if (rd_log[s_rd % 8] !== 4'hC) begin n_bad++; $display("FAIL rd_addr: got %h want c", rd_log[s_rd % 8]); end
    n_cmp++;
    if (m !== 8'h3C) begin n_bad++; $display("FAIL rd_miso: got %h want 3c", m); end
    n_cmp++;
    if (wr_cnt - s_wr !== 0) begin n_bad++; $display("FAIL rd_no_wr: got %0d want 0", wr_cnt - s_wr); end
    n_cmp++;
    if (sel_cnt - s_sel !== 1) begin n_bad++; $display("FAIL rd_sel: got %0d want 1", sel_cnt - s_sel); end
    n_cmp++;
    if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL rd_miso_idle: got %b want 0", spi_miso); end
  endtask

  task automatic test_abort();
    int s_sel = sel_cnt, s_wr = wr_cnt, s_err = err_cnt;
    logic [7:0] m;
    spi_frame(24'hA89A00, 10, 20, 1'b0, m);
    n_cmp++;
    if (wr_cnt - s_wr !== 0) begin n_bad++; $display("FAIL abort_no_wr: got %0d want 0", wr_cnt - s_wr); end
    n_cmp++;
    if (sel_cnt - s_sel !== 0) begin n_bad++; $display("FAIL abort_no_sel: got %0d want 0", sel_cnt - s_sel); end
    n_cmp++;
    if (err_cnt - s_err !== 1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", err_cnt - s_err); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    s_wr = wr_cnt;
    spi_frame(24'hB01100, 16, 20, 1'b0, m);
    n_cmp++;
    if (wr_cnt - s_wr !== 1) begin n_bad++; $display("FAIL post_abort_wr: got %0d want 1", wr_cnt - s_wr); end
    n_cmp++;
    if ({last_wr_addr, last_wr_data} !== 12'h611) begin
      n_bad++; $display("FAIL post_abort_data: got %h want 611", {last_wr_addr, last_wr_data});
    end
  endtask

  task automatic test_extra_clocks();
    int s_wr = wr_cnt, s_err = err_cnt;
    logic [7:0] m;
    spi_frame(24'hC877FF, 24, 20, 1'b0, m);
    n_cmp++;
    if (wr_cnt - s_wr !== 1) begin n_bad++; $display("FAIL extra_wr: got %0d want 1", wr_cnt - s_wr); end
    n_cmp++;
    if ({last_wr_addr, last_wr_data} !== 12'h977) begin
      n_bad++; $display("FAIL extra_data: got %h want 977", {last_wr_addr, last_wr_data});
    end
    n_cmp++;
    if (err_cnt - s_err !== 0) begin n_bad++; $display("FAIL extra_err: got %0d want 0", err_cnt - s_err); end
  endtask

  task automatic test_reset_mid_frame();
    int s_sel = sel_cnt, s_err = err_cnt, s_wr = wr_cnt;
    logic [7:0] m;
    spi_frame(24'hA89A00, 12, 0, 1'b1, m);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({spi_miso, addr_bus, addr_sel, wr_en, wr_data, rd_en, busy, frame_err} !== 18'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %h want 0",
               {spi_miso, addr_bus, addr_sel, wr_en, wr_data, rd_en, busy, frame_err});
    end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_stay_idle: got %b want 0", busy); end
    spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ((sel_cnt - s_sel) + (err_cnt - s_err) !== 0) begin
      n_bad++; $display("FAIL midrst_silent: strobes+errs %0d want 0", (sel_cnt - s_sel) + (err_cnt - s_err));
    end
    spi_frame(24'hF85500, 16, 20, 1'b0, m);
    n_cmp++;
    if (wr_cnt - s_wr !== 1) begin n_bad++; $display("FAIL midrst_next_wr: got %0d want 1", wr_cnt - s_wr); end
    n_cmp++;
    if ({last_wr_addr, last_wr_data} !== 12'hF55) begin
      n_bad++; $display("FAIL midrst_next_data: got %h want f55", {last_wr_addr, last_wr_data});
    end
  endtask

  task automatic test_back_to_back();
    int s_rd = rd_cnt, s_err = err_cnt;
    logic [7:0] m1, m2;
    spi_frame(24'h180000, 16, 4, 1'b0, m1);
    spi_frame(24'h500000, 16, 20, 1'b0, m2);
    n_cmp++;
    if (rd_cnt - s_rd !== 2) begin n_bad++; $display("FAIL b2b_rd_pulses: got %0d want 2", rd_cnt - s_rd); end
    n_cmp++;
    if ({rd_log[s_rd % 8], rd_log[(s_rd + 1) % 8]} !== 8'h3A) begin
      n_bad++; $display("FAIL b2b_addrs: got %h want 3a", {rd_log[s_rd % 8], rd_log[(s_rd + 1) % 8]});
    end
    n_cmp++;
    if ({m1, m2} !== 16'hA55A) begin n_bad++; $display("FAIL b2b_miso: got %h want a55a", {m1, m2}); end
    n_cmp++;
    if (err_cnt - s_err !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt - s_err); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) rd_log[i] = 4'h0;
    rd_mem[12] = 8'h3C;
    rd_mem[3]  = 8'hA5;
    rd_mem[10] = 8'h5A;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_clocks();
    test_reset_mid_frame();
    test_back_to_back();
    n_cmp++;
    if (bad_strobe !== 0) begin n_bad++; $display("FAIL strobe_rules: got %0d bad cycles want 0", bad_strobe); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
